// File: rtl/bp_cce_fetch_unit.sv
// CCE microcode fetch unit: single-port instruction RAM shared between the INIT-time
// programming port and the FETCH pipeline. Define BP_CCE_FETCH_PARITY_EN for per-word parity.
module bp_cce_fetch_unit #(
    parameter int instr_width_p = 48,
    parameter int pc_width_p    = 8,
    parameter int els_p         = 256,
    parameter int start_pc_p    = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     mode_normal_i,
    input  logic                     ucode_v_i,
    input  logic                     ucode_w_i,
    input  logic [pc_width_p-1:0]    ucode_addr_i,
    input  logic [instr_width_p-1:0] ucode_data_i,
    output logic                     ucode_ready_o,
    output logic                     ucode_v_o,
    output logic [instr_width_p-1:0] ucode_data_o,
    input  logic [pc_width_p-1:0]    predicted_pc_i,
    input  logic [pc_width_p-1:0]    branch_pc_i,
    input  logic                     stall_i,
    input  logic                     mispredict_i,
    output logic [pc_width_p-1:0]    fetch_pc_o,
    output logic [instr_width_p-1:0] inst_o,
    output logic                     inst_v_o,
    output logic                     pc_err_o
);

    typedef enum logic [2:0] {
        S_RESET,
        S_INIT,
        S_INIT_END,
        S_FETCH,
        S_ERROR
    } state_e;

    localparam logic [pc_width_p:0]   els_lp      = (pc_width_p+1)'(els_p);
    localparam logic [pc_width_p-1:0] start_pc_lp = pc_width_p'(start_pc_p);

    state_e                     state_r;
    logic [pc_width_p-1:0]      fetch_pc_r;
    logic                       inst_v_r;
    logic                       pc_err_r;
    logic                       ucode_v_r;
    logic                       ready_r;
    logic [instr_width_p-1:0]   rd_data_r;

    logic [instr_width_p-1:0]   mem [0:els_p-1];

    logic                       hs;
    logic                       prog_in_range;
    logic [pc_width_p-1:0]      next_pc;
    logic                       next_in_range;
    logic                       par_err;
    logic                       ram_en;
    logic                       ram_we;
    logic [pc_width_p-1:0]      ram_addr;

    assign hs            = ucode_v_i & ready_r;
    assign prog_in_range = {1'b0, ucode_addr_i} < els_lp;
    assign next_pc       = stall_i      ? fetch_pc_r  :
                           mispredict_i ? branch_pc_i : predicted_pc_i;
    assign next_in_range = {1'b0, next_pc} < els_lp;

`ifdef BP_CCE_FETCH_PARITY_EN
    logic par_mem [0:els_p-1];
    logic rd_par_r;

    // Stored bit makes the word plus parity even; only meaningful on a presented fetch.
    assign par_err = (state_r == S_FETCH) & inst_v_r & (rd_par_r != (^rd_data_r));
`else
    assign par_err = 1'b0;
`endif

    // The programming port owns the RAM in INIT; fetch reads only happen outside it.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = next_pc;
        if (!reset_i) begin
            case (state_r)
                S_INIT: begin
                    if (hs) begin
                        ram_en   = prog_in_range;
                        ram_we   = ucode_w_i;
                        ram_addr = ucode_addr_i;
                    end
                end
                S_INIT_END: begin
                    ram_en   = 1'b1;
                    ram_addr = start_pc_lp;
                end
                S_FETCH: begin
                    ram_en = next_in_range & ~par_err;
                end
                default: begin
                    ram_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_en && ram_we) begin
            mem[ram_addr] <= ucode_data_i;
`ifdef BP_CCE_FETCH_PARITY_EN
            par_mem[ram_addr] <= ^ucode_data_i;
`endif
        end else if (ram_en) begin
            rd_data_r <= mem[ram_addr];
`ifdef BP_CCE_FETCH_PARITY_EN
            rd_par_r <= par_mem[ram_addr];
`endif
        end else if (hs && !ucode_w_i) begin
            // Accepted read beyond the RAM depth answers with zero.
            rd_data_r <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= S_RESET;
            fetch_pc_r <= '0;
            inst_v_r   <= 1'b0;
            pc_err_r   <= 1'b0;
            ucode_v_r  <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            ucode_v_r <= hs & ~ucode_w_i;
            case (state_r)
                S_RESET: begin
                    state_r <= S_INIT;
                    ready_r <= 1'b1;
                end
                S_INIT: begin
                    if (mode_normal_i && !hs) begin
                        state_r <= S_INIT_END;
                        ready_r <= 1'b0;
                    end
                end
                S_INIT_END: begin
                    fetch_pc_r <= start_pc_lp;
                    inst_v_r   <= 1'b1;
                    state_r    <= S_FETCH;
                end
                S_FETCH: begin
                    if (par_err || !next_in_range) begin
                        inst_v_r <= 1'b0;
                        pc_err_r <= 1'b1;
                        state_r  <= S_ERROR;
                    end else begin
                        fetch_pc_r <= next_pc;
                    end
                end
                S_ERROR: begin
                    inst_v_r <= 1'b0;
                    pc_err_r <= 1'b1;
                end
                default: begin
                    state_r <= S_RESET;
                end
            endcase
        end
    end

    assign ucode_ready_o = ready_r;
    assign ucode_v_o     = ucode_v_r;
    assign ucode_data_o  = rd_data_r;
    assign fetch_pc_o    = fetch_pc_r;
    assign inst_o        = rd_data_r;
    assign inst_v_o      = inst_v_r & (state_r == S_FETCH) & ~par_err;
    assign pc_err_o      = pc_err_r;

endmodule

// File: tb/tb_bp_cce_fetch_unit.sv
// Scoreboard bench for bp_cce_fetch_unit (els_p=200): directed programming and fetch vectors.
module tb_bp_cce_fetch_unit;

    localparam int IW  = 48;
    localparam int PW  = 8;
    localparam int ELS = 200;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          mode_normal_i = 1'b0;
    logic          ucode_v_i = 1'b0;
    logic          ucode_w_i = 1'b0;
    logic [PW-1:0] ucode_addr_i = '0;
    logic [IW-1:0] ucode_data_i = '0;
    logic          ucode_ready_o;
    logic          ucode_v_o;
    logic [IW-1:0] ucode_data_o;
    logic [PW-1:0] predicted_pc_i = '0;
    logic [PW-1:0] branch_pc_i = '0;
    logic          stall_i = 1'b0;
    logic          mispredict_i = 1'b0;
    logic [PW-1:0] fetch_pc_o;
    logic [IW-1:0] inst_o;
    logic          inst_v_o;
    logic          pc_err_o;

    bp_cce_fetch_unit #(
        .instr_width_p(IW),
        .pc_width_p(PW),
        .els_p(ELS),
        .start_pc_p(0)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .mode_normal_i(mode_normal_i),
        .ucode_v_i(ucode_v_i),
        .ucode_w_i(ucode_w_i),
        .ucode_addr_i(ucode_addr_i),
        .ucode_data_i(ucode_data_i),
        .ucode_ready_o(ucode_ready_o),
        .ucode_v_o(ucode_v_o),
        .ucode_data_o(ucode_data_o),
        .predicted_pc_i(predicted_pc_i),
        .branch_pc_i(branch_pc_i),
        .stall_i(stall_i),
        .mispredict_i(mispredict_i),
        .fetch_pc_o(fetch_pc_o),
        .inst_o(inst_o),
        .inst_v_o(inst_v_o),
        .pc_err_o(pc_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [IW-1:0]    model [0:255];
    logic [IW-1:0]    exp_ucode_q[$];
    logic [PW+IW-1:0] exp_fetch_q[$];
    logic [PW-1:0]    cur_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [IW-1:0] word(input int i);
        return {8'hC3, 8'(i), 16'h5A00 | 16'(i * 3), 16'(i * 7 + 1)};
    endfunction

    task automatic ucode_write(input logic [PW-1:0] addr, input logic [IW-1:0] data);
        ucode_v_i    = 1'b1;
        ucode_w_i    = 1'b1;
        ucode_addr_i = addr;
        ucode_data_i = data;
        if (int'(addr) < ELS) model[addr] = data;
        @(posedge clk); #1;
        ucode_v_i = 1'b0;
    endtask

    task automatic ucode_read(input logic [PW-1:0] addr);
        ucode_v_i    = 1'b1;
        ucode_w_i    = 1'b0;
        ucode_addr_i = addr;
        exp_ucode_q.push_back((int'(addr) < ELS) ? model[addr] : '0);
        @(posedge clk); #1;
        ucode_v_i = 1'b0;
    endtask

    // One FETCH cycle: drive selection inputs and predict the PC shown next cycle.
    task automatic fetch_step(input logic stall, input logic misp,
                              input logic [PW-1:0] bpc, input logic [PW-1:0] ppc);
        logic [PW-1:0] nxt;
        nxt = stall ? cur_pc : (misp ? bpc : ppc);
        stall_i        = stall;
        mispredict_i   = misp;
        branch_pc_i    = bpc;
        predicted_pc_i = ppc;
        if (int'(nxt) < ELS) exp_fetch_q.push_back({nxt, model[nxt]});
        cur_pc = nxt;
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 10 && !ucode_ready_o; i++) begin
            @(posedge clk); #1;
        end
        check("init_ready", 64'(ucode_ready_o), 64'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_fetch_pc", 64'(fetch_pc_o), 64'd0);
        check("rst_inst_v", 64'(inst_v_o), 64'd0);
        check("rst_ucode_ready", 64'(ucode_ready_o), 64'd0);
        check("rst_ucode_v", 64'(ucode_v_o), 64'd0);
        check("rst_pc_err", 64'(pc_err_o), 64'd0);
    endtask

    // Monitor: every presented response must match the head of its queue.
    initial begin
        logic [IW-1:0]    eu;
        logic [PW+IW-1:0] ef;
        forever begin
            @(negedge clk);
            if (ucode_v_o) begin
                if (exp_ucode_q.size() == 0) begin
                    check("ucode_v_spurious", 64'(ucode_v_o), 64'd0);
                end else begin
                    eu = exp_ucode_q.pop_front();
                    check("ucode_data", 64'(ucode_data_o), 64'(eu));
                end
            end
            if (inst_v_o) begin
                if (exp_fetch_q.size() == 0) begin
                    check("inst_v_spurious", 64'(inst_v_o), 64'd0);
                end else begin
                    ef = exp_fetch_q.pop_front();
                    check("fetch_pc", 64'(fetch_pc_o), 64'(ef[PW+IW-1:IW]));
                    check("fetch_inst", 64'(inst_o), 64'(ef[IW-1:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) model[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset_i = 1'b0;
        @(posedge clk); #1;
        wait_ready();

        for (int i = 0; i < 16; i++) ucode_write(PW'(i), word(i));
        for (int i = 32; i < 35; i++) ucode_write(PW'(i), word(i));
        ucode_write(8'd199, word(199));
        ucode_write(8'd3, 48'hA5);
        ucode_read(8'd3);
        ucode_read(8'h21);
        ucode_write(8'd210, 48'hFFFF_0000_FFFF);
        ucode_read(8'd210);

        // A handshake in the same cycle as mode_normal keeps the FSM in INIT.
        mode_normal_i = 1'b1;
        ucode_read(8'd199);
        check("init_hold_ready", 64'(ucode_ready_o), 64'd1);
        exp_fetch_q.push_back({8'd0, model[0]});
        @(posedge clk); #1;
        check("init_end_ready", 64'(ucode_ready_o), 64'd0);
        check("init_end_inst_v", 64'(inst_v_o), 64'd0);
        @(posedge clk); #1;
        cur_pc = 8'd0;

        // Programming traffic while fetching must be ignored.
        ucode_v_i    = 1'b1;
        ucode_w_i    = 1'b1;
        ucode_addr_i = 8'd5;
        ucode_data_i = 48'hDEAD_BEEF_0000;

        for (int i = 1; i <= 5; i++) fetch_step(1'b0, 1'b0, 8'h00, PW'(i));
        fetch_step(1'b1, 1'b0, 8'h00, 8'd6);
        fetch_step(1'b1, 1'b0, 8'h00, 8'd6);
        fetch_step(1'b0, 1'b0, 8'h00, 8'd6);
        fetch_step(1'b0, 1'b1, 8'h20, 8'h07);
        fetch_step(1'b1, 1'b1, 8'h10, 8'h07);
        fetch_step(1'b0, 1'b0, 8'h00, 8'h21);
        fetch_step(1'b0, 1'b0, 8'h00, 8'd200);

        ucode_w_i    = 1'b0;
        ucode_addr_i = 8'd3;
        for (int i = 0; i < 3; i++) begin
            check("err_pc_err", 64'(pc_err_o), 64'd1);
            check("err_inst_v", 64'(inst_v_o), 64'd0);
            check("err_ucode_ready", 64'(ucode_ready_o), 64'd0);
            @(posedge clk); #1;
        end

        ucode_v_i     = 1'b0;
        mode_normal_i = 1'b0;
        stall_i       = 1'b0;
        mispredict_i  = 1'b0;
        reset_i       = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs();
        reset_i = 1'b0;
        @(posedge clk); #1;
        wait_ready();
        check("post_rst_pc_err", 64'(pc_err_o), 64'd0);

`ifdef BP_CCE_FETCH_PARITY_EN
        dut.par_mem[4] = ~dut.par_mem[4];
        mode_normal_i = 1'b1;
        exp_fetch_q.push_back({8'd0, model[0]});
        @(posedge clk); #1;
        @(posedge clk); #1;
        cur_pc = 8'd0;
        for (int i = 1; i <= 3; i++) fetch_step(1'b0, 1'b0, 8'h00, PW'(i));
        predicted_pc_i = 8'd4;
        @(posedge clk); #1;
        check("par_fetch_pc", 64'(fetch_pc_o), 64'd4);
        check("par_inst_v", 64'(inst_v_o), 64'd0);
        @(posedge clk); #1;
        check("par_pc_err", 64'(pc_err_o), 64'd1);
        check("par_inst_v_err", 64'(inst_v_o), 64'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("ucode_q_drained", 64'(exp_ucode_q.size()), 64'd0);
        check("fetch_q_drained", 64'(exp_fetch_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_cce_fetch_unit.md
BP_CCE_FETCH_UNIT -- requirements
Module: bp_cce_fetch_unit

Interface
REQ-001 SHALL have parameter instr_width_p, default 48, meaning microcode instruction width in bits.
REQ-002 SHALL have parameter pc_width_p, default 8, meaning fetch PC width.
REQ-003 SHALL have parameter els_p, default 256, meaning instruction RAM depth; must satisfy 2 <= els_p <= 2^pc_width_p.
REQ-004 SHALL have parameter start_pc_p, default 0, meaning first PC fetched after INIT_END; must be < els_p.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; reset is synchronous and active-high.
REQ-006 SHALL have port reset_i, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port mode_normal_i, input, 1 bit, meaning 1 = leave INIT and fetch; 0 = remain in uncached/INIT.
REQ-008 SHALL have ports ucode_v_i (in, 1), ucode_w_i (in, 1), ucode_addr_i (in, pc_width_p), ucode_data_i (in, instr_width_p), meaning the programming request.
REQ-009 SHALL have port ucode_ready_o, output, 1 bit, meaning a programming request is accepted when ucode_v_i & ucode_ready_o.
REQ-010 SHALL have ports ucode_v_o (out, 1) and ucode_data_o (out, instr_width_p), meaning read-response valid and data.
REQ-011 SHALL have ports predicted_pc_i and branch_pc_i, input, pc_width_p each, meaning pre-decode predicted PC and EX-resolved PC.
REQ-012 SHALL have ports stall_i and mispredict_i, input, 1 bit each.
REQ-013 SHALL have ports fetch_pc_o (out, pc_width_p), inst_o (out, instr_width_p), inst_v_o (out, 1).
REQ-014 SHALL have port pc_err_o, output, 1 bit, meaning a sticky out-of-range fetch error.

Function
REQ-015 SHALL implement the FSM states RESET, INIT, INIT_END, FETCH, ERROR.
REQ-016 SHALL transition RESET->INIT unconditionally after one cycle.
REQ-017 SHALL, in INIT, assert ucode_ready_o=1 and go to INIT_END when mode_normal_i=1 and no request handshakes that cycle; otherwise stay in INIT.
REQ-018 SHALL, in INIT_END, drive ucode_ready_o=0, issue a RAM read at start_pc_p, load fetch_pc_r<=start_pc_p and inst_v_r<=1, and go to FETCH.
REQ-019 SHALL, in FETCH, select next PC by priority: stall_i -> fetch_pc_r; else mispredict_i -> branch_pc_i; else predicted_pc_i.
REQ-020 SHALL, in FETCH, read the RAM every cycle, so inst_o corresponds to fetch_pc_o one cycle after selection with 1-cycle latency.
REQ-021 SHALL treat a selected next PC >= els_p as out of range: perform no RAM read, set inst_v_r<=0 and pc_err_o<=1, and go to ERROR.
REQ-022 SHALL treat ERROR as terminal until reset, with inst_v_o=0, ucode_ready_o=0, and pc_err_o held at 1.
REQ-023 SHALL perform an accepted write in the same cycle, producing no response.
REQ-024 SHALL, for an accepted read, assert ucode_v_o=1 for exactly the next cycle with ucode_data_o = RAM[addr].
REQ-025 SHALL ignore ucode_v_i whenever ucode_ready_o=0, without side effects.
REQ-026 SHALL give the programming port exclusive use of the RAM port whenever ucode_ready_o=1; fetch reads never collide.
REQ-027 SHALL, with a programming address >= els_p, accept the request, drop a write, and return zero data for a read.
REQ-028 SHALL never drive inst_v_o=1 outside FETCH.

Reset
REQ-029 SHALL, while reset_i=1, force state=RESET, fetch_pc_o=0, inst_v_o=0, ucode_ready_o=0, ucode_v_o=0, pc_err_o=0.
REQ-030 SHALL allow reset asserted mid-FETCH or mid-programming to abort the in-flight operation, leaving RAM contents unspecified only for a write accepted in that cycle.
REQ-031 SHALL leave RAM contents unreset; software reprograms them in INIT.

Configuration
REQ-032 SHALL, when BP_CCE_FETCH_PARITY_EN is defined, store an even-parity bit per word, generated on write and checked on every fetch read.
REQ-033 SHALL, when BP_CCE_FETCH_PARITY_EN is defined, treat a parity mismatch on a valid fetch as an error: deassert inst_v_o that cycle, set pc_err_o, and enter ERROR.
REQ-034 SHALL, when BP_CCE_FETCH_PARITY_EN is not defined, omit the parity bit and checker, with pc_err_o reflecting only out-of-range PCs.

Verification
REQ-035 SHALL cover: write 0xA5 to addr 3 in INIT, then read addr 3 -> ucode_v_o=1 exactly one cycle later with data 0xA5.
REQ-036 SHALL cover: mode_normal_i=1 with start_pc_p=0 and predicted_pc_i=pc+1 -> after INIT_END, fetch_pc_o steps 0,1,2 with inst_v_o=1 and inst_o=RAM[pc].
REQ-037 SHALL cover: stall_i=1 for 2 cycles at pc=5 -> fetch_pc_o stays 5 and inst_o is stable, then pc 6 is fetched.
REQ-038 SHALL cover: stall_i=0, mispredict_i=1, branch_pc_i=0x20, predicted_pc_i=0x07 -> next fetch_pc_o=0x20; with stall_i=1 as well, the PC holds.
REQ-039 SHALL cover: els_p=200 with predicted_pc_i=200 -> pc_err_o=1, inst_v_o=0, state ERROR until reset; reset then clears pc_err_o to 0.
REQ-040 SHALL cover, with BP_CCE_FETCH_PARITY_EN defined: corrupt a stored parity bit at pc 4 by backdoor -> fetch of pc 4 gives inst_v_o=0 and pc_err_o=1.
